// File: rtl/spi_dac_streamer_mc.sv
// Multi-lane SPI (mode 0) DAC transmitter: shared SCK/CS_n, one MOSI per channel, exact frame timing.
// Optional build macro SPI_DAC_OFFSET_BIN_EN inverts each word's MSB at accept (offset-binary DACs).
`timescale 1ns/1ps

module spi_dac_streamer_mc #(
    parameter int CH_NUM  = 2,
    parameter int DATA_W  = 16,
    parameter int SCK_DIV = 10,
    parameter int CS_GAP  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [CH_NUM*DATA_W-1:0] i_data,
    output logic                     o_sck,
    output logic                     o_cs_n,
    output logic [CH_NUM-1:0]        o_mosi,
    output logic                     o_frame_done
);

    localparam int SR_W  = CH_NUM * DATA_W;
    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    state_e            state_q,   state_d;
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [BIT_W-1:0]  bit_q,     bit_d;
    logic [GAP_W-1:0]  gap_q,     gap_d;
    logic [SR_W-1:0]   shreg_q,   shreg_d;
    logic              sck_q,     sck_d;
    logic              cs_n_q,    cs_n_d;
    logic [CH_NUM-1:0] mosi_q,    mosi_d;
    logic              ready_q,   ready_d;
    logic              done_q,    done_d;

    logic              half_tick;
    logic [SR_W-1:0]   load_word;

`ifdef SPI_DAC_OFFSET_BIN_EN
    localparam logic [SR_W-1:0] MSB_MASK = {CH_NUM{1'b1, {(DATA_W-1){1'b0}}}};
    assign load_word = i_data ^ MSB_MASK;
`else
    assign load_word = i_data;
`endif

    assign half_tick = (div_q == DIV_LAST);

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;
        sck_d   = sck_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        ready_d = ready_q;
        done_d  = 1'b0;

        if (state_q != ST_IDLE) begin
            div_d = half_tick ? '0 : div_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_valid && ready_q) begin
                    shreg_d = load_word;
                    ready_d = 1'b0;
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    for (int c = 0; c < CH_NUM; c++) begin
                        mosi_d[c] = load_word[c*DATA_W + DATA_W - 1];
                    end
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (half_tick) begin
                    sck_d   = 1'b1;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (half_tick) begin
                    if (sck_q) begin
                        // Falling half-tick: the DAC has sampled the current bit, present the next.
                        sck_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            mosi_d  = '0;
                            state_d = ST_HOLD;
                        end else begin
                            bit_d = bit_q + 1'b1;
                            for (int c = 0; c < CH_NUM; c++) begin
                                mosi_d[c] = shreg_q[c*DATA_W + DATA_W - 2];
                                shreg_d[c*DATA_W +: DATA_W] =
                                    {shreg_q[c*DATA_W +: DATA_W-1], 1'b0};
                            end
                        end
                    end else begin
                        sck_d = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (half_tick) begin
                    cs_n_d = 1'b1;
                    if (CS_GAP == 0) begin
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                if (half_tick) begin
                    if (gap_q == GAP_LAST) begin
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the shift register is cleared on reset too; it is cheap here and keeps the
    // first frame after a mid-frame reset independent of stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            shreg_q <= '0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop updates from pre-edge values.
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_sck        = sck_q;
    assign o_cs_n       = cs_n_q;
    assign o_mosi       = mosi_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_spi_dac_streamer_mc.sv
// Bench for spi_dac_streamer_mc: default instance plus a minimal-parameter instance,
// each checked every cycle against a timeline model derived from the frame timing rules.
`timescale 1ns/1ps

module tb_spi_dac_streamer_mc;

`ifdef SPI_DAC_OFFSET_BIN_EN
    localparam bit OFFSET_EN = 1'b1;
`else
    localparam bit OFFSET_EN = 1'b0;
`endif

    // Main instance: defaults. Boundary instance: SCK_DIV=1, CS_GAP=0, DATA_W=2, CH_NUM=1.
    localparam int M_T = 10, M_DW = 16, M_G = 3;
    localparam int M_L = M_T * (2*M_DW + 1 + M_G);
    localparam int B_T = 1,  B_DW = 2,  B_G = 0;
    localparam int B_L = B_T * (2*B_DW + 1 + B_G);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        i_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic        o_ready, o_sck, o_cs_n, o_frame_done;
    logic [1:0]  o_mosi;

    logic        bi_valid = 1'b0;
    logic [1:0]  bi_data = '0;
    logic        bo_ready, bo_sck, bo_cs_n, bo_frame_done;
    logic [0:0]  bo_mosi;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_dac_streamer_mc u_dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .o_sck(o_sck), .o_cs_n(o_cs_n), .o_mosi(o_mosi), .o_frame_done(o_frame_done)
    );

    spi_dac_streamer_mc #(.CH_NUM(1), .DATA_W(2), .SCK_DIV(1), .CS_GAP(0)) u_bnd (
        .clk(clk), .rst_n(rst_n), .i_valid(bi_valid), .o_ready(bo_ready), .i_data(bi_data),
        .o_sck(bo_sck), .o_cs_n(bo_cs_n), .o_mosi(bo_mosi), .o_frame_done(bo_frame_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Reference timeline model ----------------
    // t = clk edges since the accept edge; h = SCK half-ticks elapsed.
    function automatic logic exp_sck(input int T, input int dw, input int t);
        int h = t / T;
        return (h % 2 == 1) && (h < 2*dw);
    endfunction

    function automatic logic exp_cs_n(input int T, input int dw, input int t);
        return !(t < T * (2*dw + 1));
    endfunction

    function automatic logic exp_mosi(input int T, input int dw, input int t, input logic [31:0] w);
        int h = t / T;
        if (h >= 2*dw) return 1'b0;
        return w[dw - 1 - h/2];
    endfunction

    function automatic logic [31:0] tx_word(input logic [31:0] w, input int dw, input int ch);
        logic [31:0] r = w;
        if (OFFSET_EN) begin
            for (int c = 0; c < ch; c++) r[c*dw + dw - 1] = ~r[c*dw + dw - 1];
        end
        return r;
    endfunction

    int          m_t = 0, b_t = 0;
    bit          m_busy = 0, m_done = 0, b_busy = 0, b_done = 0;
    logic [31:0] m_word = '0, b_word = '0;
    logic [31:0] m_q[$];
    logic [31:0] b_q[$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_t = 0; m_q.delete();
            b_busy = 0; b_done = 0; b_t = 0; b_q.delete();
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_t++;
                if (m_t == M_L) begin m_busy = 0; m_done = 1; end
            end else if (i_valid) begin
                m_busy = 1; m_t = 0;
                m_word = tx_word(i_data, M_DW, 2);
                m_q.push_back(m_word);
            end
            b_done = 0;
            if (b_busy) begin
                b_t++;
                if (b_t == B_L) begin b_busy = 0; b_done = 1; end
            end else if (bi_valid) begin
                b_busy = 1; b_t = 0;
                b_word = tx_word(32'(bi_data), B_DW, 1);
                b_q.push_back(b_word);
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial forever begin
        logic [5:0] me;
        logic [4:0] be;
        @(negedge clk);
        if (m_busy)
            me = {exp_sck(M_T, M_DW, m_t), exp_cs_n(M_T, M_DW, m_t), 2'b00,
                  exp_mosi(M_T, M_DW, m_t, 32'(m_word[31:16])),
                  exp_mosi(M_T, M_DW, m_t, 32'(m_word[15:0]))};
        else
            me = {1'b0, 1'b1, 1'b1, m_done, 2'b00};
        check("main_cycle", 64'({o_sck, o_cs_n, o_ready, o_frame_done, o_mosi}), 64'(me));
        if (b_busy)
            be = {exp_sck(B_T, B_DW, b_t), exp_cs_n(B_T, B_DW, b_t), 2'b00,
                  exp_mosi(B_T, B_DW, b_t, b_word)};
        else
            be = {1'b0, 1'b1, 1'b1, b_done, 1'b0};
        check("bnd_cycle", 64'({bo_sck, bo_cs_n, bo_ready, bo_frame_done, bo_mosi}), 64'(be));
    end

    // Receiver view: shift in MOSI on SCK rising edges, compare whole words when CS_n rises.
    initial begin
        logic [15:0] c0 = '0, c1 = '0;
        logic [1:0]  bc = '0;
        int          mn = 0, bn = 0;
        logic        ps = 0, pcs = 1, bps = 0, bpcs = 1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                c0 = '0; c1 = '0; bc = '0; mn = 0; bn = 0;
                ps = 0; pcs = 1; bps = 0; bpcs = 1;
            end else begin
                if (o_sck && !ps && !o_cs_n) begin
                    c0 = {c0[14:0], o_mosi[0]}; c1 = {c1[14:0], o_mosi[1]}; mn++;
                end
                if (!pcs && o_cs_n) begin
                    check("main_rx_bits", 64'(mn), 64'(M_DW));
                    if (m_q.size() == 0) check("main_rx_unexpected", 64'(1), 64'(0));
                    else check("main_rx_word", 64'({c1, c0}), 64'(m_q.pop_front()));
                    mn = 0;
                end
                ps = o_sck; pcs = o_cs_n;
                if (bo_sck && !bps && !bo_cs_n) begin
                    bc = {bc[0], bo_mosi[0]}; bn++;
                end
                if (!bpcs && bo_cs_n) begin
                    check("bnd_rx_bits", 64'(bn), 64'(B_DW));
                    if (b_q.size() == 0) check("bnd_rx_unexpected", 64'(1), 64'(0));
                    else check("bnd_rx_word", 64'(bc), 64'(b_q.pop_front()));
                    bn = 0;
                end
                bps = bo_sck; bpcs = bo_cs_n;
            end
        end
    end

    // ---------------- Directed frames with hand-computed expectations ----------------
    task automatic main_frame(input logic [31:0] data, input logic [15:0] e0, input logic [15:0] e1);
        int cs_low = 0, rises = 0, first_rise = -1, last_rise = -1, gap_bad = 0;
        int ready_at = -1, dones = 0;
        logic [15:0] c0 = '0, c1 = '0;
        logic ps = 0;
        @(negedge clk); i_data = data; i_valid = 1'b1;
        @(negedge clk); i_valid = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (!o_cs_n) cs_low++;
            if (o_sck && !ps) begin
                if (rises > 0 && t - last_rise != 20) gap_bad++;
                if (rises == 0) first_rise = t;
                last_rise = t; rises++;
                c0 = {c0[14:0], o_mosi[0]}; c1 = {c1[14:0], o_mosi[1]};
            end
            ps = o_sck;
            if (o_frame_done) dones++;
            if (o_ready && ready_at < 0) ready_at = t;
            @(negedge clk);
        end
        check("frame_cs_low_cycles", 64'(cs_low), 64'(330));
        check("frame_sck_rises", 64'(rises), 64'(16));
        check("frame_first_rise", 64'(first_rise), 64'(10));
        check("frame_rise_spacing", 64'(gap_bad), 64'(0));
        check("frame_ready_return", 64'(ready_at), 64'(360));
        check("frame_done_pulses", 64'(dones), 64'(1));
        check("frame_lane0", 64'(c0), 64'(e0));
        check("frame_lane1", 64'(c1), 64'(e1));
    endtask

    task automatic bnd_frame(input logic [1:0] data, input logic [1:0] e);
        int cs_low = 0, ready_at = -1, cs_up_at = -1, r0 = -1, r1 = -1, rises = 0;
        logic [1:0] c = '0;
        logic ps = 0;
        @(negedge clk); bi_data = data; bi_valid = 1'b1;
        @(negedge clk); bi_valid = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (!bo_cs_n) cs_low++;
            if (bo_cs_n && cs_up_at < 0) cs_up_at = t;
            if (bo_ready && ready_at < 0) ready_at = t;
            if (bo_sck && !ps) begin
                if (rises == 0) r0 = t; else r1 = t;
                rises++; c = {c[0], bo_mosi[0]};
            end
            ps = bo_sck;
            @(negedge clk);
        end
        check("bnd_cs_low_cycles", 64'(cs_low), 64'(5));
        check("bnd_sck_rises", 64'(rises), 64'(2));
        check("bnd_sck_period", 64'(r1 - r0), 64'(2));
        check("bnd_ready_at", 64'(ready_at), 64'(5));
        check("bnd_cs_rise_at", 64'(cs_up_at), 64'(5));
        check("bnd_word", 64'(c), 64'(e));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        logic [31:0] w;

        // Reset and quiet idle.
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({o_cs_n, o_sck, o_mosi, o_ready, o_frame_done}), 64'(6'b100010));
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_outputs", 64'({o_cs_n, o_sck, o_mosi, o_ready, o_frame_done}), 64'(6'b100010));

        // Single frames with literal expectations.
        main_frame({16'hA5C3, 16'h0F01}, OFFSET_EN ? 16'h8F01 : 16'h0F01,
                   OFFSET_EN ? 16'h25C3 : 16'hA5C3);
        main_frame({16'h1234, 16'h8000}, OFFSET_EN ? 16'h0000 : 16'h8000,
                   OFFSET_EN ? 16'h9234 : 16'h1234);

        // Back-to-back with random data changing every cycle: exactly four frames.
        dones = 0;
        @(negedge clk); i_valid = 1'b1; i_data = $urandom;
        for (int j = 0; j < 4*361; j++) begin
            @(negedge clk);
            i_data = $urandom;
            if (o_frame_done) dones++;
        end
        i_valid = 1'b0;
        check("b2b_done_count", 64'(dones), 64'(4));
        repeat (5) @(negedge clk);

        // Randomly spaced single frames.
        for (int j = 0; j < 3; j++) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            i_data = $urandom; i_valid = 1'b1;
            @(negedge clk); i_valid = 1'b0;
            repeat (365) @(negedge clk);
        end

        // Boundary instance.
        bnd_frame(2'b10, OFFSET_EN ? 2'b00 : 2'b10);
        bnd_frame(2'b01, OFFSET_EN ? 2'b11 : 2'b01);
        @(negedge clk); bi_valid = 1'b1;
        for (int j = 0; j < 40; j++) begin
            bi_data = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        bi_valid = 1'b0;
        repeat (10) @(negedge clk);

        // Reset in the middle of bit 7, then a clean frame.
        @(negedge clk); i_data = $urandom; i_valid = 1'b1;
        @(negedge clk); i_valid = 1'b0;
        repeat (150) @(negedge clk);
        check("midreset_sck_before", 64'({o_sck, o_cs_n}), 64'(2'b10));
        #2 rst_n = 1'b0;
        #1 check("midreset_async", 64'({o_cs_n, o_sck, o_mosi, o_ready}), 64'(5'b10001));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        w = $urandom;
        main_frame(w, 16'(tx_word(w, M_DW, 2)), 16'(tx_word(w, M_DW, 2) >> 16));

        repeat (5) @(negedge clk);
        check("main_frames_drained", 64'(m_q.size()), 64'(0));
        check("bnd_frames_drained", 64'(b_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
